// File: rtl/gzip_line_unpacker_pkg.sv
`timescale 1ns/1ps
// Shared widths for the host-line to decompressor-word unpacker.
// Combinational constants only; no latency or backpressure of their own.
package lynxTypes;
    localparam int AXI_DATA_BITS = 512;
endpackage

package common;
    import lynxTypes::*;

    localparam int COMP_DATA_BITS = 64;
    localparam int UNPACK_LANES   = AXI_DATA_BITS / COMP_DATA_BITS;

    // Index width for an n-lane mask; a single lane still needs one bit.
    function automatic int lane_idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/gzip_line_unpacker_lane_select.sv
`timescale 1ns/1ps
// Picks the lowest pending lane of a mask and flags when it is the only one left.
// Purely combinational; no backpressure of its own.
module lane_select #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic          last_o
);
    logic seen;
    logic multi;

    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mask_i[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
        last_o = seen & ~multi;
    end
endmodule

// File: rtl/gzip_line_unpacker.sv
`timescale 1ns/1ps
// Splits host cache lines into decompressor words, lowest lane first (UNPACK_SKIP_EMPTY_EN drops zero-keep lanes).
// Latency: first word the cycle after line accept, then 1 word/cycle with no bubble between lines.
// Backpressure: line input is ready only when empty or when the final pending lane handshakes.
module gzip_line_unpacker
    import lynxTypes::*;
    import common::*;
#(
    parameter int LINE_BITS = AXI_DATA_BITS,
    parameter int WORD_BITS = COMP_DATA_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LINE_BITS-1:0]   i_data_tdata_i,
    input  logic [LINE_BITS/8-1:0] i_data_tkeep_i,
    input  logic                   i_data_tlast_i,
    input  logic                   i_data_tvalid_i,
    output logic                   i_data_tready_o,
    output logic [WORD_BITS-1:0]   o_data_tdata_o,
    output logic [WORD_BITS/8-1:0] o_data_tkeep_o,
    output logic                   o_data_tlast_o,
    output logic                   o_data_tvalid_o,
    input  logic                   o_data_tready_i
);
    localparam int N  = LINE_BITS / WORD_BITS;
    localparam int KB = WORD_BITS / 8;
    localparam int IW = lane_idx_bits(N);

    localparam logic STATE_EMPTY = 1'b0;
    localparam logic STATE_DRAIN = 1'b1;

    logic                   state_q, state_d;
    logic [N-1:0]           mask_q, mask_d;
    logic [LINE_BITS-1:0]   data_q, data_d;
    logic [LINE_BITS/8-1:0] keep_q, keep_d;
    logic                   last_q, last_d;

    logic [N-1:0]  lane_kz;
    logic [N-1:0]  new_mask;
    logic [IW-1:0] cur_idx;
    logic          cur_is_last;
    logic          out_hs;
    logic          final_hs;
    logic          in_hs;

    logic [WORD_BITS-1:0] lane_dat  [N];
    logic [KB-1:0]        lane_keep [N];

    lane_select #(
        .N  (N),
        .IW (IW)
    ) u_lane_select (
        .mask_i (mask_q),
        .idx_o  (cur_idx),
        .last_o (cur_is_last)
    );

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign lane_dat[g]  = data_q[WORD_BITS*g +: WORD_BITS];
        assign lane_keep[g] = keep_q[KB*g +: KB];
    end

    assign o_data_tvalid_o = (state_q == STATE_DRAIN);
    assign o_data_tdata_o  = lane_dat[cur_idx];
    assign o_data_tkeep_o  = lane_keep[cur_idx];
    assign o_data_tlast_o  = o_data_tvalid_o & last_q & cur_is_last;

    assign out_hs   = o_data_tvalid_o & o_data_tready_i;
    assign final_hs = out_hs & cur_is_last;

    // Ready is held low during reset so no line can slip in on release.
    assign i_data_tready_o = rst_n & ((state_q == STATE_EMPTY) | final_hs);
    assign in_hs           = i_data_tvalid_i & i_data_tready_o;

    always_comb begin
        lane_kz = '0;
        for (int i = 0; i < N; i++) begin
            lane_kz[i] = |i_data_tkeep_i[KB*i +: KB];
        end
    end

    always_comb begin
        logic above;
        above    = 1'b0;
        new_mask = '0;
`ifdef UNPACK_SKIP_EMPTY_EN
        new_mask = lane_kz;
`else
        // Everything up to the highest live lane is emitted, gaps included.
        for (int i = N - 1; i >= 0; i--) begin
            above       = above | lane_kz[i];
            new_mask[i] = above;
        end
`endif
        // An empty closing line still has to carry tlast downstream.
        if ((lane_kz == '0) && i_data_tlast_i) begin
            new_mask    = '0;
            new_mask[0] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (out_hs) begin
            mask_d[cur_idx] = 1'b0;
        end
        if (final_hs) begin
            state_d = STATE_EMPTY;
        end
        if (in_hs) begin
            data_d  = i_data_tdata_i;
            keep_d  = i_data_tkeep_i;
            last_d  = i_data_tlast_i;
            mask_d  = new_mask;
            state_d = (new_mask != '0) ? STATE_DRAIN : STATE_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_EMPTY;
            mask_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_gzip_line_unpacker.sv
`timescale 1ns/1ps
// Randomized bench for gzip_line_unpacker against a per-line word-list model.
module tb_gzip_line_unpacker;
    import lynxTypes::*;
    import common::*;

    localparam int LB = AXI_DATA_BITS;
    localparam int WB = COMP_DATA_BITS;
    localparam int N  = LB / WB;
    localparam int KB = WB / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LB-1:0] in_dat;
    logic [LB/8-1:0] in_keep;
    logic          in_last;
    logic          in_vld;
    logic          i_rdy;
    logic [WB-1:0] o_dat;
    logic [KB-1:0] o_keep;
    logic          o_last;
    logic          o_vld;
    logic          out_rdy;
    logic          accepted;

    always #5 clk = ~clk;

    gzip_line_unpacker dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_data_tdata_i  (in_dat),
        .i_data_tkeep_i  (in_keep),
        .i_data_tlast_i  (in_last),
        .i_data_tvalid_i (in_vld),
        .i_data_tready_o (i_rdy),
        .o_data_tdata_o  (o_dat),
        .o_data_tkeep_o  (o_keep),
        .o_data_tlast_o  (o_last),
        .o_data_tvalid_o (o_vld),
        .o_data_tready_i (out_rdy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [WB-1:0] dat;
        logic [KB-1:0] keep;
        logic          last;
    } word_t;

    word_t exp_q[$];

    // Expected output words of one accepted line, straight from the lane rules.
    task automatic model_accept(input logic [LB-1:0] d, input logic [LB/8-1:0] k, input logic l);
        int    hi;
        word_t w;
        hi = -1;
        for (int i = 0; i < N; i++) if (k[KB*i +: KB] != '0) hi = i;
        if (hi < 0) begin
            if (l) begin
                w.dat  = d[WB-1:0];
                w.keep = '0;
                w.last = 1'b1;
                exp_q.push_back(w);
            end
            return;
        end
        for (int i = 0; i <= hi; i++) begin
`ifdef UNPACK_SKIP_EMPTY_EN
            if (k[KB*i +: KB] == '0) continue;
`endif
            w.dat  = d[WB*i +: WB];
            w.keep = k[KB*i +: KB];
            w.last = l && (i == hi);
            exp_q.push_back(w);
        end
    endtask

    task automatic gen_line(input int kind);
        for (int i = 0; i < LB / 32; i++) in_dat[32*i +: 32] = $urandom;
        in_last = 1'($urandom_range(0, 1));
        in_keep = '0;
        case (kind)
            0: in_keep = '1;
            1: in_keep[7:0] = 8'hFF;
            2: begin
                in_keep[KB-1:0]    = '1;
                in_keep[KB*3 +: KB] = '1;
            end
            3: in_keep = '0;
            default: begin
                for (int i = 0; i < N; i++) begin
                    case ($urandom_range(0, 2))
                        0:       in_keep[KB*i +: KB] = '0;
                        1:       in_keep[KB*i +: KB] = '1;
                        default: in_keep[KB*i +: KB] = KB'($urandom_range(1, 255));
                    endcase
                end
            end
        endcase
    endtask

    // Compare outputs for the upcoming edge, then advance the model across it.
    task automatic sample();
        logic  exp_rdy;
        word_t w;
        exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_rdy);
        check("o_tvalid", 64'(o_vld), 64'(exp_q.size() != 0));
        check("i_tready", 64'(i_rdy), 64'(exp_rdy));
        if (exp_q.size() != 0) begin
            w = exp_q[0];
            check("o_tdata", o_dat, w.dat);
            check("o_tkeep", 64'(o_keep), 64'(w.keep));
            check("o_tlast", 64'(o_last), 64'(w.last));
            if (out_rdy) void'(exp_q.pop_front());
        end else begin
            check("o_tlast_idle", 64'(o_last), 64'(0));
        end
        accepted = in_vld && exp_rdy;
        if (accepted) model_accept(in_dat, in_keep, in_last);
    endtask

    task automatic tick(input int vld_pct, input int rdy_pct, input int kind);
        @(posedge clk);
        #1;
        if (!in_vld || accepted) begin
            accepted = 1'b0;
            in_vld   = ($urandom_range(0, 99) < vld_pct);
            if (in_vld) gen_line(kind);
        end
        out_rdy = ($urandom_range(0, 99) < rdy_pct);
        @(negedge clk);
        sample();
    endtask

    task automatic drain();
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0 && (!in_vld || accepted)) break;
            tick(0, 100, 0);
        end
        @(posedge clk);
        #1;
        in_vld   = 1'b0;
        accepted = 1'b0;
    endtask

    initial begin
        in_dat   = '0;
        in_keep  = '0;
        in_last  = 1'b0;
        in_vld   = 1'b0;
        out_rdy  = 1'b0;
        accepted = 1'b0;
        #2;
        check("rst_tvalid", 64'(o_vld), 64'(0));
        check("rst_tready", 64'(i_rdy), 64'(0));
        check("rst_tlast", 64'(o_last), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sample();

        // Directed keep patterns, full throughput, back-to-back lines.
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 20; c++) tick(100, 100, k);
            drain();
        end
        // Stall pattern 1,0,0,1 while draining full lines.
        for (int c = 0; c < 40; c++) tick(100, ((c % 4) == 1 || (c % 4) == 2) ? 0 : 100, 0);
        drain();
        for (int c = 0; c < 2000; c++) tick(70, 60, $urandom_range(0, 6));
        drain();

        // Reset in the middle of a full line.
        @(posedge clk);
        #1;
        gen_line(0);
        in_last  = 1'b1;
        in_vld   = 1'b1;
        accepted = 1'b0;
        out_rdy  = 1'b1;
        @(negedge clk);
        sample();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            in_vld = 1'b0;
            @(negedge clk);
            sample();
        end
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", 64'(o_vld), 64'(0));
        check("midrst_tready", 64'(i_rdy), 64'(0));
        check("midrst_tlast", 64'(o_last), 64'(0));
        exp_q.delete();
        in_vld   = 1'b0;
        accepted = 1'b0;
        @(posedge clk);
        @(negedge clk);
        gen_line(4);
        in_vld  = 1'b1;
        out_rdy = 1'b1;
        rst_n   = 1'b1;
        #1;
        sample();
        for (int c = 0; c < 500; c++) tick(80, 70, $urandom_range(0, 6));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gzip_line_unpacker.md
GZIP_LINE_UNPACKER -- requirements
Module: gzip_line_unpacker

Interface
REQ-001 Parameter LINE_BITS, default AXI_DATA_BITS (512): width of the input cache-line stream.
REQ-002 Parameter WORD_BITS, default COMP_DATA_BITS (64): width of the decompressor-side word stream.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_data  AXI4S.s  LINE_BITS  cache lines from host, carrying tdata, tkeep, tlast, tvalid and tready.
REQ-006 o_data  AXI4S.m  WORD_BITS  word stream to the gzip decompressor core, carrying tdata, tkeep, tlast, tvalid and tready.

Function
REQ-007 The block SHALL split each accepted line into N = LINE_BITS/WORD_BITS lanes, with lane i = tdata[WORD_BITS*i +: WORD_BITS] and keep[WORD_BITS/8*i +: WORD_BITS/8].
REQ-008 The block SHALL emit lanes in ascending index order, one word per o_data handshake.
REQ-009 FSM: EMPTY (no line held) -> DRAIN on an i_data handshake; DRAIN -> EMPTY when the final pending lane handshakes and no new line is accepted in the same cycle; DRAIN -> DRAIN otherwise.
REQ-010 On acceptance, the block SHALL capture tdata, tkeep, tlast and an emit mask, both registered.
REQ-011 The emit mask SHALL contain lanes 0 up to the highest lane with nonzero keep (gap lanes included), unless modified by REQ-022.
REQ-012 i_data.tready = (state == EMPTY) OR (o_data handshake on the final pending lane this cycle), giving back-to-back lines with no bubble.
REQ-013 Latency: first word valid on the cycle after line acceptance; sustained throughput SHALL be 1 word/cycle.
REQ-014 o_data.tvalid SHALL be 1 exactly in DRAIN; tdata/tkeep SHALL be the lowest pending lane; they SHALL be stable while tvalid=1 and tready=0.
REQ-015 o_data.tlast SHALL be 1 only on the final pending lane of a line captured with tlast=1.
REQ-016 Line with all-zero tkeep and tlast=0: the block SHALL accept and drop it, emitting nothing and remaining in EMPTY.
REQ-017 Line with all-zero tkeep and tlast=1: the block SHALL emit one word with lane-0 data, tkeep=0 and tlast=1.
REQ-018 Simultaneous final-lane handshake and new line acceptance: the pending mask SHALL be replaced by the new mask, and the next cycle SHALL present the new line's first lane.
REQ-019 Lane pointer and mask arithmetic SHALL be sized $clog2(N) and N bits respectively, with no wrap beyond lane N-1.

Reset
REQ-020 While rst_n=0, the block SHALL force state=EMPTY, mask=0, o_data.tvalid=0, o_data.tlast=0 and i_data.tready=0; o_data.tdata/tkeep are don't-care.
REQ-021 Reset asserted mid-line SHALL discard remaining lanes; after release, i_data.tready SHALL be 1 in the first cycle.

Configuration
REQ-022 With UNPACK_SKIP_EMPTY_EN defined, lanes with zero keep SHALL be excluded from the emit mask (only nonzero-keep lanes are emitted) while REQ-016/017 still apply; without it, REQ-011 holds unchanged.

Structure
REQ-023 COMP_DATA_BITS and the lane-count constant SHALL live in package common; AXI_DATA_BITS SHALL come from lynxTypes.
REQ-024 Lowest-set-bit selection and the "single bit remaining" detect SHALL be one sub-module, lane_select (N-bit mask in; index and last-flag out).

Verification
REQ-025 Full line, keep=all ones, tlast=1, o_data.tready=1 -> 8 words over 8 consecutive cycles starting 1 cycle after accept; tlast only on word 7.
REQ-026 keep=0x0000_0000_0000_00FF, tlast=0 -> exactly 1 word (lane 0), tkeep=0xFF, tlast=0.
REQ-027 keep with lanes 0 and 3 nonzero, tlast=1 -> without macro: 4 words, lanes 1-2 tkeep=0, tlast on lane 3; with UNPACK_SKIP_EMPTY_EN: 2 words (lanes 0 and 3), tlast on lane 3.
REQ-028 Two full lines back-to-back, tready=1 -> 16 contiguous words with no idle cycle; i_data.tready high on cycle of word 7.
REQ-029 tready toggled 1,0,0,1 during drain -> words held stable while stalled; no lane lost or duplicated.
REQ-030 rst_n pulsed low after word 2 of 8 -> tvalid=0 immediately (async); after release, no remaining lanes appear and a new line is accepted on the first cycle.
